// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter that shares one UART TX byte stream among several
// AXI-stream sources, with an optional channel-ID header byte before each packet.
module uart_tx_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ID_PREFIX  = 1,
  parameter int unsigned MAX_BEATS  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            active
);

  localparam int unsigned IdW  = $clog2(NUM_PORTS);
  localparam int unsigned CntW = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [IdW:0]    NumP    = (IdW + 1)'(NUM_PORTS);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_BEATS);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        grant_q, grant_d;
  logic [IdW-1:0]        last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;

  logic           slot_free;
  logic [IdW:0]   arb_sum;
  logic [IdW-1:0] arb_idx;
  logic [IdW-1:0] pick;
  logic           cnt_hit;

  assign slot_free = !tvalid_q || m_axis_tready;

  // Scan from the farthest offset down so the nearest valid port after last_q wins.
  always_comb begin
    pick    = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      arb_sum = {1'b0, last_q} + (IdW + 1)'(off);
      if (arb_sum >= NumP) begin
        arb_sum = arb_sum - NumP;
      end
      arb_idx = arb_sum[IdW-1:0];
      if (s_axis_tvalid[arb_idx]) begin
        pick = arb_idx;
      end
    end
  end

  assign cnt_hit = (MAX_BEATS != 0) && ((cnt_q + CntW'(1)) == MaxCnt);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q && !m_axis_tready;
    s_axis_tready = '0;
    unique case (state_q)
      StIdle: begin
        if (|s_axis_tvalid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = (ID_PREFIX != 0) ? StHdr : StData;
        end
      end
      StHdr: begin
        if (slot_free) begin
          tdata_d            = '0;
          tdata_d[IdW-1:0]   = grant_q;
          tvalid_d           = 1'b1;
          state_d            = StData;
        end
      end
      StData: begin
        s_axis_tready[grant_q] = slot_free;
        if (slot_free && s_axis_tvalid[grant_q]) begin
          tdata_d  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
          tvalid_d = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          if (s_axis_tlast[grant_q] || cnt_hit) begin
            last_d  = grant_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= IdW'(NUM_PORTS - 1);
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign grant_id      = grant_q;
  assign active        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a cycle table for one port, then queue-driven packet scenarios
// on default, MAX_BEATS=3 and ID_PREFIX=0 instances.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic        m_tready;

  logic [3:0] tr0, tr1, tr2, s_tready;
  logic [7:0] md0, md1, md2, md;
  logic       mv0, mv1, mv2, mv;
  logic [1:0] gid0, gid1, gid2, gid;
  logic       act0, act1, act2, act;

  always #5 clk = ~clk;

  uart_tx_arb #(.DATA_WIDTH(8), .NUM_PORTS(4), .ID_PREFIX(1), .MAX_BEATS(0)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(tr0), .m_axis_tdata(md0), .m_axis_tvalid(mv0),
    .m_axis_tready(m_tready), .grant_id(gid0), .active(act0)
  );

  uart_tx_arb #(.DATA_WIDTH(8), .NUM_PORTS(4), .ID_PREFIX(1), .MAX_BEATS(3)) dut_mb (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(tr1), .m_axis_tdata(md1), .m_axis_tvalid(mv1),
    .m_axis_tready(m_tready), .grant_id(gid1), .active(act1)
  );

  uart_tx_arb #(.DATA_WIDTH(8), .NUM_PORTS(4), .ID_PREFIX(0), .MAX_BEATS(0)) dut_np (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(tr2), .m_axis_tdata(md2), .m_axis_tvalid(mv2),
    .m_axis_tready(m_tready), .grant_id(gid2), .active(act2)
  );

  int sel;
  always_comb begin
    s_tready = tr0; md = md0; mv = mv0; gid = gid0; act = act0;
    if (sel == 1) begin
      s_tready = tr1; md = md1; mv = mv1; gid = gid1; act = act1;
    end else if (sel == 2) begin
      s_tready = tr2; md = md2; mv = mv2; gid = gid2; act = act2;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic       ea;
    logic [3:0] et;
    logic [1:0] eg;
  } vec_t;

  vec_t tbl[12];

  // Queue-driven source/sink model
  logic [8:0] srcq [4][$];
  logic [7:0] obs[$];
  logic [7:0] exp_q[$];
  int   cyc;
  int   first_valid;
  int   rdy_mode;
  int   onehot_err;
  int   stable_err;
  logic prev_stall;
  logic [7:0] prev_data;
  logic smp_mv;
  logic [7:0] smp_md;

  task automatic clear_src();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
  endtask

  task automatic step();
    logic [3:0] hs;
    logic       ohs;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*8 +: 8] = srcq[i][0][7:0];
        s_tlast[i]        = srcq[i][0][8];
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*8 +: 8] = 8'h00;
        s_tlast[i]        = 1'b0;
      end
    end
    m_tready = (rdy_mode == 0) ? 1'b1 : (cyc % 10 == 0);
    #1;
    if ($countones(s_tready) > 1) onehot_err++;
    if (prev_stall && md != prev_data) stable_err++;
    prev_stall = mv && !m_tready;
    prev_data  = md;
    if (mv && first_valid < 0) first_valid = cyc;
    smp_mv = mv;
    smp_md = md;
    hs  = s_tvalid & s_tready;
    ohs = mv && m_tready;
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (hs[i]) void'(srcq[i].pop_front());
    if (ohs) obs.push_back(smp_md);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start_test();
    obs.delete();
    exp_q.delete();
    cyc         = 0;
    first_valid = -1;
    onehot_err  = 0;
    stable_err  = 0;
    prev_stall  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_src();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_test();
  endtask

  task automatic chk_out(input string name);
    chk({name, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs.size()) chk($sformatf("%s_b%0d", name, i), obs[i], exp_q[i]);
    end
  endtask

  initial begin
    int found;
    sel = 0;
    rdy_mode = 0;
    rst = 1'b1;
    m_tready = 1'b1;
    clear_src();

    // Port 2 single packets: 0x41,0x42 then a stalled 0x43
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd0};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0000, 2'd2};
    tbl[2]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 4'b0100, 2'd2};
    tbl[3]  = '{1'b1, 8'h42, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 4'b0100, 2'd2};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 4'b0000, 2'd2};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 1'b0, 4'b0000, 2'd2};
    tbl[6]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 4'b0000, 2'd2};
    tbl[7]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 8'h42, 1'b1, 4'b0000, 2'd2};
    tbl[8]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 4'b0000, 2'd2};
    tbl[9]  = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 4'b0100, 2'd2};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h43, 1'b0, 4'b0000, 2'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h43, 1'b0, 4'b0000, 2'd2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_dflt", {mv0, md0, act0, tr0, gid0}, 32'h0);
    chk("reset_mb",   {mv1, md1, act1, tr1, gid1}, 32'h0);
    chk("reset_np",   {mv2, md2, act2, tr2, gid2}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s_tvalid = {1'b0, tbl[i].v, 2'b00};
      s_tdata  = {8'h00, tbl[i].d, 16'h0000};
      s_tlast  = {1'b0, tbl[i].l, 2'b00};
      m_tready = tbl[i].r;
      #1;
      chk($sformatf("vec%0d", i), {mv, md, act, s_tready, gid},
          {tbl[i].ev, tbl[i].ed, tbl[i].ea, tbl[i].et, tbl[i].eg});
    end

    // Contention: port 0 also queues a second packet, so port 1 must go before it
    do_reset();
    srcq[0].push_back({1'b1, 8'hA0});
    srcq[0].push_back({1'b1, 8'hB0});
    srcq[1].push_back({1'b1, 8'hA1});
    srcq[3].push_back({1'b1, 8'hA3});
    run(60);
    exp_q = '{8'h00, 8'hA0, 8'h01, 8'hA1, 8'h03, 8'hA3, 8'h00, 8'hB0};
    chk_out("contend");
    chk("hdr_latency", first_valid, 2);
    chk("contend_idle", act, 1'b0);

    // Backpressure: downstream ready one cycle in ten
    do_reset();
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) srcq[1].push_back({(b == 3), 8'h31 + 8'(b)});
    run(150);
    exp_q = '{8'h01, 8'h31, 8'h32, 8'h33, 8'h34};
    chk_out("bp");
    chk("bp_onehot", onehot_err, 0);
    chk("bp_stable", stable_err, 0);
    rdy_mode = 0;

    // MAX_BEATS=3 splits a 5-byte packet
    sel = 1;
    do_reset();
    for (int b = 0; b < 5; b++) srcq[1].push_back({(b == 4), 8'h10 + 8'(b)});
    run(40);
    exp_q = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h01, 8'h13, 8'h14};
    chk_out("maxb");

    // No header
    sel = 2;
    do_reset();
    srcq[3].push_back({1'b1, 8'h55});
    run(20);
    exp_q = '{8'h55};
    chk_out("nohdr");
    chk("nohdr_latency", first_valid, 2);

    // Reset mid-packet
    sel = 0;
    do_reset();
    srcq[0].push_back({1'b0, 8'h60});
    srcq[0].push_back({1'b0, 8'h61});
    srcq[0].push_back({1'b1, 8'h62});
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (smp_mv && smp_md == 8'h60) found = 1;
    end
    chk("rst_reach", found, 1);
    @(negedge clk);
    rst = 1'b1;
    clear_src();
    @(posedge clk);
    #1;
    chk("rst_abort", {mv, s_tready, act}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    start_test();
    srcq[0].push_back({1'b1, 8'h70});
    run(20);
    exp_q = '{8'h00, 8'h70};
    chk_out("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
